// File: rtl/mul_pkg.sv
// Shared constants and types for the HI/LO multiply/divide units.
// Funct codes are common to the multiplier and the restoring divider.
package mul_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // 32'h80000000 maps to itself, read as unsigned 2^31
  function automatic logic [WIDTH-1:0] abs_val(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditional 33-bit add of the
// multiplicand into the high half, then a 65-bit right shift.
module mul_step
  import mul_pkg::*;
(
  input  logic [WIDTH:0]   i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_magA,
  output logic [WIDTH:0]   o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum    = i_acc_lo[0] ? i_acc_hi + {1'b0, i_magA} : i_acc_hi;
    o_acc_hi = {1'b0, w_sum[WIDTH:1]};
    o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential 32x32 shift-add multiplier (MULT/MULTU) for HI/LO.
// 32 iteration cycles plus one sign-fix cycle; result is {HI, LO}.
module seq_multiplier
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  input  logic [5:0]           Signal,
  output logic [2*WIDTH-1:0]   dataOut,
  output logic                 busy,
  output logic                 done
);

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_e               r_state;
  state_e               w_next;
  logic [5:0]           r_cnt;
  logic [WIDTH:0]       r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [WIDTH-1:0]     r_magA;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_out;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [WIDTH:0]       w_step_hi;
  logic [WIDTH-1:0]     w_step_lo;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_accept = (r_state == IDLE) &&
                    (Signal == MULT || Signal == MULTU);
  assign w_signed = (Signal == MULT);
  assign w_magA   = w_signed ? abs_val(dataA) : dataA;
  assign w_magB   = w_signed ? abs_val(dataB) : dataB;
  assign w_prod   = {r_acc_hi[WIDTH-1:0], r_acc_lo};

  mul_step u_step (
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_magA   (r_magA),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_magA   <= '0;
      r_neg    <= 1'b0;
      r_out    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_magA   <= w_magA;
            r_acc_lo <= w_magB;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_neg    <= w_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          end
        end
        RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt + 6'd1;
        end
        FIX: begin
          r_out  <= r_neg ? -w_prod : w_prod;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dataOut = r_out;
  assign done    = r_done;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, scoreboard
// queue, and hand-written sequences for busy-ignore and reset abort.
module tb_seq_multiplier;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;

  seq_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; request is accepted on the next posedge.
  task automatic start(input logic [5:0] sig, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    Signal = sig;
    dataA  = a;
    dataB  = b;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    Signal = 6'd0;
    dataA  = $urandom;
    dataB  = $urandom;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_result(input string name);
    int          lat;
    int          bcnt;
    logic [63:0] exp;
    lat  = 0;
    bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got no done expected done", name);
      return;
    end
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s spurious: got done expected none", name);
      return;
    end
    exp = sb_q.pop_front();
    check({name, " product"}, dataOut, exp);
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " busy cycles"}, 64'(bcnt), 64'd33);
    check({name, " busy at done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;

    vecs[0] = '{"multu 3x5", MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F};
    vecs[1] = '{"multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{"mult -1x2", MULT, 32'hFFFF_FFFF, 32'd2,
                64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3] = '{"mult min2", MULT, 32'h8000_0000, 32'h8000_0000,
                64'h4000_0000_0000_0000};
    vecs[4] = '{"mult 7x-3", MULT, 32'd7, 32'hFFFF_FFFD,
                64'hFFFF_FFFF_FFFF_FFEB};
    vecs[5] = '{"multu zero", MULTU, 32'd0, 32'hDEAD_BEEF, 64'd0};
    vecs[6] = '{"mult -5x-6", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA,
                64'd30};
    vecs[7] = '{"multu shift", MULTU, 32'h1234_5678, 32'h10,
                64'h0000_0001_2345_6780};
    vecs[8] = '{"mult maxmin", MULT, 32'h7FFF_FFFF, 32'h8000_0000,
                64'hC000_0000_8000_0000};

    reset  = 1'b0;
    Signal = 6'd0;
    dataA  = 32'd0;
    dataB  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset dataOut", dataOut, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b1;

    // Non-multiply funct codes never start anything
    @(negedge clk);
    Signal = DIVU;
    dataA  = 32'd4;
    dataB  = 32'd4;
    repeat (3) @(negedge clk);
    check("divu ignored busy", 64'(busy), 64'd0);
    Signal = 6'd0;

    foreach (vecs[i]) begin
      @(negedge clk);
      start(vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_result(vecs[i].name);
      @(negedge clk);
      check({vecs[i].name, " done drop"}, 64'(done), 64'd0);
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      @(negedge clk);
      start(MULTU, ra, rb, {32'd0, ra} * {32'd0, rb});
      wait_result("multu random");
    end

    // Requests while busy are ignored; restart in the done cycle
    @(negedge clk);
    start(MULTU, 32'd6, 32'd7, 64'd42);
    fork
      wait_result("busy ignore");
      begin
        repeat (4) @(negedge clk);
        Signal = MULTU;
        dataA  = 32'd9;
        dataB  = 32'd9;
        repeat (16) @(negedge clk);
        Signal = 6'd0;
      end
    join
    start(MULTU, 32'd9, 32'd9, 64'd81);
    check("b2b done drop", 64'(done), 64'd0);
    wait_result("back to back");

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start(MULTU, 32'd6, 32'd7, 64'd42);
    wait_result("pre reset");
    @(negedge clk);
    start(MULTU, 32'd11, 32'd13, 64'd143);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort dataOut", dataOut, 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);
    check("abort hold", dataOut, 64'd0);
    start(MULTU, 32'd2, 32'd3, 64'd6);
    wait_result("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential 32x32 shift-add multiplier for the MIPS pipeline's HI/LO path. It is the multiply counterpart of the restoring divider and uses the same operand/funct-code interface. It performs MULTU and MULT over 32 iteration cycles plus one sign-fix cycle, and returns the 64-bit product as {HI, LO}.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- MULT, 6'b011000, funct code for the signed multiply.
- MULTU, 6'b011001, funct code for the unsigned multiply.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- dataA  in  32  multiplicand, sampled on the accept edge only.
- dataB  in  32  multiplier, sampled on the accept edge only.
- Signal  in  6  funct code; MULT/MULTU while idle starts an operation.
- dataOut  out  64  product {HI[63:32], LO[31:0]}; holds its value until the next completion.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when dataOut has just been updated.

## Operation
- States:
  - IDLE -> RUN on an accept edge.
  - RUN -> FIX after 32 iterations.
  - FIX -> IDLE unconditionally.
- Accept: state==IDLE and Signal is MULT or MULTU.
  - Latch magA, magB and neg.
  - Clear acc_hi (33 bits incl. carry) and iteration counter cnt (6 bits).
  - Load acc_lo = magB.
- Magnitudes:
  - MULTU: mag = operand; neg=0.
  - MULT: mag = two's-complement absolute value (32'h80000000 -> 32'h80000000 as unsigned 2^31); neg = dataA[31]^dataB[31].
- RUN iteration (one per edge):
  - If acc_lo[0], then {c, acc_hi} = acc_hi + magA (33-bit add).
  - Then shift {c, acc_hi, acc_lo} right by 1.
  - cnt += 1.
  - Leave RUN when cnt reaches 32.
- FIX: dataOut <= neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo} (64-bit two's complement); done <= 1.
- Signal values other than MULT/MULTU are ignored in every state.
- Signal==MULT/MULTU while busy is ignored: no restart, operands are not resampled.
- Zero operands take the full latency; there is no early termination.

## Timing
- Reset (reset==0, asynchronous):
  - state=IDLE, cnt=0, acc=0, dataOut=64'd0, busy=0, done=0.
  - Takes effect immediately, including mid-RUN or in FIX.
  - An aborted operation produces no done and leaves dataOut at 0.
- Accept on edge E0:
  - busy=1 from E0 until E33.
  - Iterations occur on E1..E32.
  - E32 moves the state to FIX; the FIX edge E33 writes dataOut, sets done=1, busy=0 and state=IDLE.
- done is high for exactly the cycle after E33 and is cleared on E34 unless another FIX occurs.
- Latency: 33 cycles from accept edge to a valid dataOut.
- A new request may be accepted on E33+1 (the done cycle, state IDLE), giving back-to-back throughput of one result per 34 edges.
- dataA/dataB may change freely after E0.

## Structure
- Shared package mul_pkg holds:
  - WIDTH.
  - The MULT/MULTU/DIVU funct constants, shared with the divider.
  - State encoding IDLE=2'd0, RUN=2'd1, FIX=2'd2.
- One sub-module, mul_step: a combinational single iteration.
  - Inputs: acc_hi, acc_lo, magA.
  - Outputs: next acc_hi and acc_lo.
- Top level holds the FSM, counter, magnitude and sign logic, and output registers.

## Test plan
- MULTU A=3, B=5 -> dataOut=64'h0000_0000_0000_000F. done pulses in the cycle after E33 only; busy high for 33 cycles.
- MULTU A=B=32'hFFFFFFFF -> dataOut=64'hFFFF_FFFE_0000_0001. Checks the carry into bit 32 of acc_hi.
- MULT A=32'hFFFFFFFF (-1), B=2 -> 64'hFFFF_FFFF_FFFF_FFFE.
- MULT A=B=32'h80000000 -> 64'h4000_0000_0000_0000.
- MULT A=7, B=-3 -> 64'hFFFF_FFFF_FFFF_FFEB.
- MULTU 6*7 accepted, then Signal=MULTU with A=B=9 held through cycles 5..20:
  - Result is 42; no second done follows.
  - A new request issued in the done cycle is accepted and yields its own product 33 edges later.
- reset driven to 0 asynchronously mid-clock at RUN cycle 10 after a prior result of 42:
  - dataOut=0, busy=0, done=0 immediately.
  - No done pulse from the aborted operation.
  - A following MULTU 2*3 returns 6 with the nominal latency.
